// File: rtl/lvds_pair_integrity_monitor.sv
// P/N lane-pair integrity monitor: realigns and polarity-corrects the N leg,
// flags per-beat P/N equality, tracks lock with hysteresis and counts mismatches.

// Per-lane lock FSM, match flag and saturating mismatch counter.
module lvds_lane_monitor #(
   parameter int LOCK_CNT   = 16,
   parameter int UNLOCK_CNT = 4,
   parameter int ERR_CNT_W  = 16
) (
   input  logic                 I_clk,
   input  logic                 I_rst,
   input  logic                 s1_v,
   input  logic                 eq,
   input  logic                 err_clr,
   output logic                 match,
   output logic                 locked,
   output logic                 locked_nxt,
   output logic [ERR_CNT_W-1:0] err_cnt
);
   localparam int MAX_CNT = (LOCK_CNT > UNLOCK_CNT) ? LOCK_CNT : UNLOCK_CNT;
   localparam int CNT_W   = $clog2(MAX_CNT + 1);

   typedef enum logic [1:0] {UNLOCKED, LOCKING, LOCKED, LOSING} state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [CNT_W-1:0]   cnt_inc;

   assign cnt_inc    = cnt_q + CNT_W'(1);
   assign locked     = (state_q == LOCKED) || (state_q == LOSING);
   // Lets the top register the all-locked AND on the same edge as the lanes.
   assign locked_nxt = (state_d == LOCKED) || (state_d == LOSING);

   // State, run counter, match flag and error counter registers.
   always_ff @(posedge I_clk or posedge I_rst) begin
      if (I_rst) begin
         state_q <= UNLOCKED;
         cnt_q   <= '0;
         match   <= 1'b0;
         err_cnt <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         match   <= s1_v & eq;
         // Clear has priority over a mismatch landing on the same edge.
         if (err_clr)
            err_cnt <= '0;
         else if (s1_v && !eq && (err_cnt != {ERR_CNT_W{1'b1}}))
            err_cnt <= err_cnt + ERR_CNT_W'(1);
      end
   end

   // Lock/unlock hysteresis; only valid beats advance the FSM.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (s1_v) begin
         case (state_q)
            UNLOCKED: if (eq) begin
               if (LOCK_CNT == 1) begin
                  state_d = LOCKED;
                  cnt_d   = '0;
               end else begin
                  state_d = LOCKING;
                  cnt_d   = CNT_W'(1);
               end
            end
            LOCKING: if (eq) begin
               if (cnt_inc == CNT_W'(LOCK_CNT)) begin
                  state_d = LOCKED;
                  cnt_d   = '0;
               end else begin
                  cnt_d   = cnt_inc;
               end
            end else begin
               state_d = UNLOCKED;
               cnt_d   = '0;
            end
            LOCKED: if (!eq) begin
               if (UNLOCK_CNT == 1) begin
                  state_d = UNLOCKED;
                  cnt_d   = '0;
               end else begin
                  state_d = LOSING;
                  cnt_d   = CNT_W'(1);
               end
            end
            LOSING: if (!eq) begin
               if (cnt_inc == CNT_W'(UNLOCK_CNT)) begin
                  state_d = UNLOCKED;
                  cnt_d   = '0;
               end else begin
                  cnt_d   = cnt_inc;
               end
            end else begin
               state_d = LOCKED;
               cnt_d   = '0;
            end
            default: begin
               state_d = UNLOCKED;
               cnt_d   = '0;
            end
         endcase
      end
   end
endmodule

module lvds_pair_integrity_monitor #(
   parameter int DATA_W     = 7,
   parameter int LANES      = 2,
   parameter int LOCK_CNT   = 16,
   parameter int UNLOCK_CNT = 4,
   parameter int ERR_CNT_W  = 16
) (
   input  logic                       I_clk,
   input  logic                       I_rst,
   input  logic                       I_valid,
   input  logic                       I_invert_n,
   input  logic                       I_err_clr,
   input  logic [LANES*DATA_W-1:0]    I_diff_pdata,
   input  logic [LANES*DATA_W-1:0]    I_diff_ndata,
   output logic [LANES*DATA_W-1:0]    O_phase_align_pdata,
   output logic [LANES*DATA_W-1:0]    O_phase_align_ndata,
   output logic                       O_valid,
   output logic [LANES-1:0]           O_lane_match,
   output logic [LANES-1:0]           O_lane_locked,
   output logic                       O_all_locked,
   output logic [LANES*ERR_CNT_W-1:0] O_err_cnt
);
   localparam int STAGES = 2;

   logic [LANES-1:0][DATA_W-1:0] s1_p, s1_n;
   logic [STAGES-1:0]            vld_pipe;   // [0] = S1 valid, [1] = output valid
   logic [LANES-1:0]             lane_eq;
   logic [LANES-1:0]             lane_locked_nxt;

   // S1 capture with N-leg polarity correction, then S2 output register.
   always_ff @(posedge I_clk or posedge I_rst) begin
      if (I_rst) begin
         s1_p                <= '0;
         s1_n                <= '0;
         vld_pipe            <= '0;
         O_phase_align_pdata <= '0;
         O_phase_align_ndata <= '0;
         O_all_locked        <= 1'b0;
      end else begin
         s1_p                <= I_diff_pdata;
         s1_n                <= I_invert_n ? ~I_diff_ndata : I_diff_ndata;
         vld_pipe            <= {vld_pipe[0], I_valid};
         O_phase_align_pdata <= s1_p;
         O_phase_align_ndata <= s1_n;
         O_all_locked        <= &lane_locked_nxt;
      end
   end

   assign O_valid = vld_pipe[STAGES-1];

   for (genvar k = 0; k < LANES; k++) begin : g_lane
      assign lane_eq[k] = (s1_p[k] == s1_n[k]);

      lvds_lane_monitor #(
         .LOCK_CNT   (LOCK_CNT),
         .UNLOCK_CNT (UNLOCK_CNT),
         .ERR_CNT_W  (ERR_CNT_W)
      ) u_lane (
         .I_clk      (I_clk),
         .I_rst      (I_rst),
         .s1_v       (vld_pipe[0]),
         .eq         (lane_eq[k]),
         .err_clr    (I_err_clr),
         .match      (O_lane_match[k]),
         .locked     (O_lane_locked[k]),
         .locked_nxt (lane_locked_nxt[k]),
         .err_cnt    (O_err_cnt[k*ERR_CNT_W +: ERR_CNT_W])
      );
   end
endmodule
